ipsa_ingress_arbiter: RTL and testbench
=======================================

Name: ipsa_ingress_arbiter

Overview:
- Shares the single 1024-bit IPSA pipeline input (en/data/last, no backpressure) between NUM_REQ ingress adapters, e.g. the CMAC AXI adapter and the PCIe/host injector.
- Arbitrates at packet granularity with round-robin. Holds the grant until the owner's last beat.
- Enforces a maximum packet length by truncating and then draining over-long packets.
- Sits between the ingress AXI adapters and the IPSA pipeline in the top-level shell.

Parameters:
- DATA_WIDTH, 1024, beat width of requester and IPSA data.
- NUM_REQ, 2, number of requesters (2..4).
- MAX_BEATS, 64, maximum beats forwarded per packet (≥2).
- CNT_WIDTH, 32, width of each per-requester packet counter.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester beat accept.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  last beat of the packet.
- ipsa_en_in  out  1  beat valid to IPSA.
- ipsa_data_in  out  DATA_WIDTH  beat data to IPSA.
- ipsa_last_in  out  1  last beat to IPSA.
- owner  out  2  index of the current/most recent grant.
- busy  out  1  high in FWD or DRAIN.
- pkt_count  out  NUM_REQ*CNT_WIDTH  packets forwarded per requester; wraps.
- trunc_count  out  16  number of truncated packets; saturates at 0xFFFF.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0.
  - All req_ready=0; ipsa_en_in=0, ipsa_last_in=0, ipsa_data_in=0.
  - pkt_count=0, trunc_count=0, busy=0.
  - Reset asserted mid-packet abandons the packet. No last is emitted.
- Transfer condition: req_valid[owner] && req_ready[owner]. req_ready is high only for owner, and only in FWD or DRAIN. The other requesters see req_ready=0.
- IDLE:
  - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - On a win: owner<=winner, beat_cnt<=0, state<=FWD.
  - With no request: stay in IDLE.
  - req_ready is low in IDLE, so packets are separated by at least one idle cycle.
- FWD:
  - On each transfer, the output registers load on the next edge, giving 1-cycle latency:
    - ipsa_en_in<=1.
    - ipsa_data_in<=req_data[owner].
    - ipsa_last_in<=req_last[owner] || beat_cnt==MAX_BEATS-1.
    - beat_cnt<=beat_cnt+1.
  - A cycle with no transfer gives ipsa_en_in<=0, ipsa_last_in<=0, and holds ipsa_data_in.
  - Transfer with req_last: pkt_count[owner]++, rr_ptr<=(owner+1)%NUM_REQ, state<=IDLE.
  - Transfer with !req_last and beat_cnt==MAX_BEATS-1 (truncation):
    - The output carries last=1.
    - pkt_count[owner]++ and trunc_count++ (saturating).
    - state<=DRAIN.
  - If req_last coincides with beat_cnt==MAX_BEATS-1, this is a normal end, not a truncation.
- DRAIN:
  - req_ready[owner]=1. Accepted beats are discarded and ipsa_en_in stays 0.
  - Transfer with req_last: rr_ptr<=(owner+1)%NUM_REQ, state<=IDLE.
- Requester valid may drop mid-packet; the grant persists indefinitely until last.
- busy=(state!=IDLE). owner holds its value after returning to IDLE.
- Counters wrap at 2^CNT_WIDTH. A counter increments in the same edge as the output beat it accounts for.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, req_ready=00.
- Single beat: req0 sends 1 beat, data=0xA5..A5, last=1 -> req_ready[0] high in the cycle after valid; ipsa_en_in=1 and ipsa_last_in=1 with data 0xA5..A5 one cycle after the handshake; pkt_count[0]=1.
- Round-robin: both requesters continuously offer 3-beat packets -> IPSA sees owner sequence 0,1,0,1; no interleaving within a packet; ≥1 idle output cycle between packets; after 4 packets, pkt_count=2/2.
- Stalls: req1 sends a 4-beat packet with valid gaps at beats 2 and 3 -> exactly 4 ipsa_en_in pulses, last only on the 4th; req0 stays blocked (req_ready[0]=0) until req1's last is accepted.
- Truncation: MAX_BEATS=64, req0 sends 70 beats -> 64 beats output, last on beat 64; beats 65..70 accepted but not output; trunc_count=1, pkt_count[0]=1; next grant goes to req1 if it is valid.
- Async reset mid-packet: assert reset at beat 2 of a 5-beat packet between clock edges -> outputs clear immediately without waiting for an edge; after release, state is IDLE, rr_ptr=0, and a new packet from req1 is forwarded normally.

Source files
------------

// File: rtl/ipsa_ingress_arbiter.sv
// Packet-granular round-robin arbiter sharing the IPSA pipeline input between
// NUM_REQ ingress adapters. Over-long packets are cut at MAX_BEATS and their
// remaining beats are drained.
module ipsa_ingress_arbiter #(
    parameter int unsigned DATA_WIDTH = 1024,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned MAX_BEATS  = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic                            ipsa_en_in,
    output logic [DATA_WIDTH-1:0]           ipsa_data_in,
    output logic                            ipsa_last_in,
    output logic [1:0]                      owner,
    output logic                            busy,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    pkt_count,
    output logic [15:0]                     trunc_count
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             owner_q, owner_d;
    logic [1:0]             rr_q, rr_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   en_q, en_d;
    logic                   last_q, last_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q [NUM_REQ];
    logic [15:0]            trunc_q;
    logic                   pkt_inc, trunc_inc;

    logic                   found;
    logic [1:0]             winner;
    int unsigned            scan_idx;
    logic                   xfer;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [1:0]             next_ptr;

    // Round-robin scan of requests starting at rr_q
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_q) + k) % NUM_REQ;
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = 2'(scan_idx);
            end
        end
    end

    // Owner-side handshake and payload selection
    always_comb begin
        xfer     = req_valid[owner_q] & ready_q[owner_q];
        sel_last = req_last[owner_q];
        sel_data = req_data[32'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
        next_ptr = 2'((32'(owner_q) + 1) % NUM_REQ);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        en_d      = 1'b0;
        last_d    = 1'b0;
        data_d    = data_q;
        pkt_inc   = 1'b0;
        trunc_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    beat_d  = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (xfer) begin
                    en_d   = 1'b1;
                    data_d = sel_data;
                    last_d = sel_last || (beat_q == LAST_BEAT);
                    beat_d = beat_q + BEAT_W'(1);
                    if (sel_last) begin
                        pkt_inc = 1'b1;
                        rr_d    = next_ptr;
                        state_d = IDLE;
                    end else if (beat_q == LAST_BEAT) begin
                        pkt_inc   = 1'b1;
                        trunc_inc = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && sel_last) begin
                    rr_d    = next_ptr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = busy_d ? (NUM_REQ'(1) << owner_d) : '0;
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Control and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
            ready_q <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    // Per-requester packet counters (wrap) and saturating truncation counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REQ); i++) pkt_cnt_q[i] <= '0;
            trunc_q <= '0;
        end else begin
            if (pkt_inc) pkt_cnt_q[owner_q] <= pkt_cnt_q[owner_q] + CNT_WIDTH'(1);
            if (trunc_inc && trunc_q != 16'hFFFF) trunc_q <= trunc_q + 16'd1;
        end
    end

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_cnt
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt_q[g];
    end

    assign req_ready    = ready_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign ipsa_en_in   = en_q;
    assign ipsa_last_in = last_q;
    assign ipsa_data_in = data_q;
    assign trunc_count  = trunc_q;

endmodule

// File: tb/tb_ipsa_ingress_arbiter.sv
// Bench for ipsa_ingress_arbiter: directed reset/latency/async-reset checks,
// then randomized packet traffic against a packet-level reference model.
module tb_ipsa_ingress_arbiter;

    localparam int unsigned DW   = 1024;
    localparam int unsigned NR   = 2;
    localparam int unsigned MB   = 64;
    localparam int unsigned CW   = 32;
    localparam int unsigned PKTS = 6;

    logic               clock = 1'b0;
    logic               reset;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_last;
    logic               ipsa_en_in;
    logic [DW-1:0]      ipsa_data_in;
    logic               ipsa_last_in;
    logic [1:0]         owner;
    logic               busy;
    logic [NR*CW-1:0]   pkt_count;
    logic [15:0]        trunc_count;

    ipsa_ingress_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BEATS  (MB),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_last     (req_last),
        .ipsa_en_in   (ipsa_en_in),
        .ipsa_data_in (ipsa_data_in),
        .ipsa_last_in (ipsa_last_in),
        .owner        (owner),
        .busy         (busy),
        .pkt_count    (pkt_count),
        .trunc_count  (trunc_count)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got[63:0]=%0h exp[63:0]=%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int unsigned salt, input int unsigned beat);
        logic [DW-1:0] d;
        for (int j = 0; j < int'(DW / 32); j++)
            d[j*32 +: 32] = salt ^ (beat * 32'h9E3779B9) ^ 32'(j);
        return d;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        int unsigned   own;
    } beat_t;

    beat_t        exp_q[$];
    int unsigned  pkt_len  [NR][PKTS];
    int unsigned  pkt_salt [NR][PKTS];
    int unsigned  cur_pkt  [NR];
    int unsigned  cur_beat [NR];
    bit           pend     [NR];
    int unsigned  len_tab  [8] = '{1, 2, 3, 5, 63, 64, 65, 70};

    logic [DW-1:0] pat;
    logic [NR-1:0] v, l;
    beat_t         e;
    int            exp_trunc;
    int            cyc;
    int            en_seen;
    bit            prev_last;
    bit            drv_done;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset = 1'b0;

        // Quiet after reset
        repeat (10) @(negedge clock);
        check("rst_en",    ipsa_en_in,   0);
        check("rst_last",  ipsa_last_in, 0);
        check("rst_data",  ipsa_data_in, 0);
        check("rst_ready", req_ready,    0);
        check("rst_busy",  busy,         0);
        check("rst_owner", owner,        0);
        check("rst_pkt",   pkt_count,    0);
        check("rst_trunc", trunc_count,  0);

        // Single-beat packet from requester 0
        pat = {(DW/32){32'hA5A5A5A5}};
        req_valid = 2'b01;
        req_last  = 2'b01;
        req_data[0 +: DW] = pat;
        @(negedge clock);
        check("sb_ready", req_ready,  2'b01);
        check("sb_busy",  busy,       1);
        check("sb_en0",   ipsa_en_in, 0);
        @(negedge clock);
        check("sb_en",    ipsa_en_in,   1);
        check("sb_last",  ipsa_last_in, 1);
        check("sb_data",  ipsa_data_in, pat);
        check("sb_pkt0",  pkt_count[0 +: CW], 1);
        check("sb_rdy_off", req_ready, 0);
        req_valid = '0;
        req_last  = '0;
        @(negedge clock);
        check("sb_en_off", ipsa_en_in, 0);
        check("sb_idle",   busy,       0);

        // Asynchronous reset in the middle of a 5-beat packet
        req_valid = 2'b01;
        req_data[0 +: DW] = mk(7, 0);
        en_seen = 0;
        for (int k = 0; k < 6 && en_seen < 2; k++) begin
            @(negedge clock);
            if (ipsa_en_in) en_seen++;
        end
        check("ar_two_beats", en_seen, 2);
        #2 reset = 1'b1;
        #1;
        check("ar_en",    ipsa_en_in,  0);
        check("ar_data",  ipsa_data_in, 0);
        check("ar_ready", req_ready,   0);
        check("ar_busy",  busy,        0);
        check("ar_pkt",   pkt_count,   0);
        req_valid = '0;
        @(negedge clock) reset = 1'b0;
        req_valid = 2'b10;
        req_last  = 2'b10;
        req_data[DW +: DW] = mk(9, 0);
        @(negedge clock);
        check("ar_owner", owner, 1);
        @(negedge clock);
        check("ar_r1_en",   ipsa_en_in,   1);
        check("ar_r1_last", ipsa_last_in, 1);
        check("ar_r1_data", ipsa_data_in, mk(9, 0));
        check("ar_r1_pkt",  pkt_count[CW +: CW], 1);
        req_valid = '0;
        req_last  = '0;

        // Randomized traffic: build packets and the expected output stream
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        exp_trunc = 0;
        for (int i = 0; i < int'(NR); i++) begin
            for (int p = 0; p < int'(PKTS); p++) begin
                pkt_len[i][p]  = len_tab[$urandom_range(0, 7)];
                pkt_salt[i][p] = $urandom;
            end
            cur_pkt[i]  = 0;
            cur_beat[i] = 0;
            pend[i]     = 1'b0;
        end
        pkt_len[0][0] = 70;
        pkt_len[1][0] = 64;
        pkt_len[0][1] = 65;
        begin
            int unsigned rem [NR];
            int unsigned nxt [NR];
            int unsigned ptr;
            int unsigned w;
            int unsigned n;
            bit any;
            for (int i = 0; i < int'(NR); i++) begin rem[i] = PKTS; nxt[i] = 0; end
            ptr = 0;
            any = 1'b1;
            while (any) begin
                any = 1'b0;
                w   = 0;
                for (int k = 0; k < int'(NR); k++) begin
                    if (!any && rem[(ptr + k) % NR] > 0) begin
                        any = 1'b1;
                        w   = (ptr + k) % NR;
                    end
                end
                if (any) begin
                    n = (pkt_len[w][nxt[w]] > MB) ? MB : pkt_len[w][nxt[w]];
                    if (pkt_len[w][nxt[w]] > MB) exp_trunc++;
                    for (int b = 0; b < int'(n); b++)
                        exp_q.push_back('{mk(pkt_salt[w][nxt[w]], b), (b == int'(n) - 1), w});
                    rem[w]--;
                    nxt[w]++;
                    ptr = (w + 1) % NR;
                end
            end
        end

        cyc       = 0;
        prev_last = 1'b0;
        drv_done  = 1'b0;
        while ((exp_q.size() > 0 || !drv_done) && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            // Output monitor
            if (ipsa_en_in) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_data",  ipsa_data_in, e.data);
                    check("rnd_last",  ipsa_last_in, e.last);
                    check("rnd_owner", owner,        e.own);
                end
            end
            if (prev_last) check("pkt_gap", ipsa_en_in, 0);
            prev_last = ipsa_en_in && ipsa_last_in;
            check("last_wo_en",   ipsa_last_in & ~ipsa_en_in, 0);
            check("ready_onehot", ($countones(req_ready) <= 1), 1);
            // Requester drivers
            drv_done = 1'b1;
            for (int i = 0; i < int'(NR); i++) begin
                if (pend[i]) begin
                    cur_beat[i]++;
                    if (cur_beat[i] == pkt_len[i][cur_pkt[i]]) begin
                        cur_pkt[i]++;
                        cur_beat[i] = 0;
                    end
                end
                if (cur_pkt[i] < PKTS) begin
                    drv_done = 1'b0;
                    v[i] = (cur_beat[i] == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    l[i] = (cur_beat[i] == pkt_len[i][cur_pkt[i]] - 1);
                    req_data[i*DW +: DW] = mk(pkt_salt[i][cur_pkt[i]], cur_beat[i]);
                end else begin
                    v[i] = 1'b0;
                    l[i] = 1'b0;
                end
                pend[i] = v[i] && req_ready[i];
            end
            req_valid = v;
            req_last  = l;
        end
        if (cyc >= 20000) check("timeout", 0, 1);
        req_valid = '0;
        req_last  = '0;
        repeat (3) @(negedge clock);
        check("end_left",  exp_q.size(), 0);
        check("end_pkt0",  pkt_count[0 +: CW],  PKTS);
        check("end_pkt1",  pkt_count[CW +: CW], PKTS);
        check("end_trunc", trunc_count, exp_trunc);
        check("end_busy",  busy,        0);
        check("end_ready", req_ready,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
